// File: rtl/bramfifo_fwft_if.sv
// Handshake and status bundle for bramfifo_fwft.
// The master side drives writes, the sink ready and flush. The slave side is the FIFO.
interface bramfifo_fwft_if #(
    parameter int DATA_ = 8,
    parameter int ADDR_ = 8
) ();
    logic               flush;
    logic [DATA_-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_+1:0]   fill;
    logic               almost_full;
    logic               almost_empty;

    modport master (
        output flush, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, fill, almost_full, almost_empty
    );

    modport slave (
        input  flush, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, fill, almost_full, almost_empty
    );
endinterface

// File: rtl/bramfifo_fwft.sv
// First-word-fall-through FIFO built on a simple dual-port block RAM with a
// 1-cycle registered read. A two-entry output stage (head + skid) hides the
// RAM read latency, so the FIFO can stream one word per cycle in each direction.

// Simple dual-port RAM: one write port and one registered read port.
module bramsd #(
    parameter int DATA_ = 8,
    parameter int ADDR_ = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [ADDR_-1:0] waddr_i,
    input  logic [DATA_-1:0] wdata_i,
    input  logic             re_i,
    input  logic [ADDR_-1:0] raddr_i,
    output logic [DATA_-1:0] rdata_o
);
    logic [DATA_-1:0] mem_q [0:(2**ADDR_)-1];
    logic [DATA_-1:0] rdata_q;

    // Write port; the array holds no reset, so its contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port: data is valid the cycle after re_i
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

module bramfifo_fwft #(
    parameter int DATA_   = 8,
    parameter int ADDR_   = 8,
    parameter int AFULL_  = (2**ADDR_) - 2,
    parameter int AEMPTY_ = 2
) (
    input  logic           clk,
    input  logic           rst,
    bramfifo_fwft_if.slave bus
);
    localparam int FW = ADDR_ + 2;
    localparam logic [ADDR_:0]   DEPTH     = {1'b1, {ADDR_{1'b0}}};
    localparam logic [ADDR_-1:0] ONE_A     = {{(ADDR_-1){1'b0}}, 1'b1};
    localparam logic [ADDR_:0]   ONE_M     = {{ADDR_{1'b0}}, 1'b1};
    localparam logic [ADDR_:0]   ZERO_M    = {(ADDR_+1){1'b0}};
    localparam logic [FW-1:0]    AFULL_TH  = FW'(AFULL_);
    localparam logic [FW-1:0]    AEMPTY_TH = FW'(AEMPTY_);

    // RAM ring state
    logic [ADDR_-1:0] wp_q, wp_d;
    logic [ADDR_-1:0] rp_q, rp_d;
    logic [ADDR_:0]   mcount_q, mcount_d;
    // A RAM read was issued last cycle and its data is on rdata_s now
    logic             inflight_q, inflight_d;
    // Output stage: head is what the sink sees, skid catches a read that lands during a stall
    logic [DATA_-1:0] head_q, head_d;
    logic [DATA_-1:0] skid_q, skid_d;
    logic [1:0]       ocount_q, ocount_d;

    logic             in_ready_s;
    logic             out_valid_s;
    logic             wr_s;
    logic             pop_s;
    logic             rd_s;
    logic [1:0]       occ_s;
    logic [DATA_-1:0] rdata_s;
    logic [FW-1:0]    fill_s;

    // Handshake qualification and the decision to issue a RAM read this cycle
    always_comb begin
        in_ready_s  = (mcount_q < DEPTH) && !rst;
        out_valid_s = (ocount_q != 2'd0);
        wr_s        = bus.in_valid && in_ready_s && !bus.flush;
        pop_s       = out_valid_s && bus.out_ready;
        occ_s       = ocount_q + {1'b0, inflight_q};
        if (bus.flush || (mcount_q == ZERO_M)) begin
            rd_s = 1'b0;
        end else if (occ_s < 2'd2) begin
            rd_s = 1'b1;
        end else begin
            // Output stage is spoken for. A pop this cycle frees the slot the new read
            // needs, which keeps full-rate streaming free of bubbles.
            rd_s = pop_s;
        end
    end

    // Next state for pointers, RAM occupancy and the output stage
    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        mcount_d   = mcount_q;
        inflight_d = rd_s;
        head_d     = head_q;
        skid_d     = skid_q;
        ocount_d   = ocount_q;
        if (bus.flush) begin
            wp_d       = {ADDR_{1'b0}};
            rp_d       = {ADDR_{1'b0}};
            mcount_d   = ZERO_M;
            inflight_d = 1'b0;
            head_d     = {DATA_{1'b0}};
            skid_d     = {DATA_{1'b0}};
            ocount_d   = 2'd0;
        end else begin
            if (wr_s) begin
                wp_d = wp_q + ONE_A;
            end else begin
                wp_d = wp_q;
            end
            if (rd_s) begin
                rp_d = rp_q + ONE_A;
            end else begin
                rp_d = rp_q;
            end
            case ({wr_s, rd_s})
                2'b10:   mcount_d = mcount_q + ONE_M;
                2'b01:   mcount_d = mcount_q - ONE_M;
                default: mcount_d = mcount_q;
            endcase
            // Pop first: the skid word, if any, advances to the head
            if (pop_s) begin
                if (ocount_q == 2'd2) begin
                    head_d   = skid_q;
                    ocount_d = 2'd1;
                end else begin
                    ocount_d = 2'd0;
                end
            end else begin
                ocount_d = ocount_q;
            end
            // Then land the RAM read into the first free slot of the output stage
            if (inflight_q) begin
                if (ocount_d == 2'd0) begin
                    head_d   = rdata_s;
                    ocount_d = 2'd1;
                end else begin
                    skid_d   = rdata_s;
                    ocount_d = 2'd2;
                end
            end else begin
                skid_d = skid_q;
            end
        end
    end

    // State registers; reset empties the FIFO immediately at any phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q       <= {ADDR_{1'b0}};
            rp_q       <= {ADDR_{1'b0}};
            mcount_q   <= ZERO_M;
            inflight_q <= 1'b0;
            head_q     <= {DATA_{1'b0}};
            skid_q     <= {DATA_{1'b0}};
            ocount_q   <= 2'd0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            mcount_q   <= mcount_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            ocount_q   <= ocount_d;
        end
    end

    // Write and read never hit the same address: reads only issue from stored words
    bramsd #(
        .DATA_ (DATA_),
        .ADDR_ (ADDR_)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_s),
        .waddr_i (wp_q),
        .wdata_i (bus.in_data),
        .re_i    (rd_s),
        .raddr_i (rp_q),
        .rdata_o (rdata_s)
    );

    assign fill_s = {1'b0, mcount_q}
                  + {{(ADDR_+1){1'b0}}, inflight_q}
                  + {{ADDR_{1'b0}}, ocount_q};

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_s;
    assign bus.out_data     = head_q;
    assign bus.fill         = fill_s;
    assign bus.almost_full  = (fill_s >= AFULL_TH);
    assign bus.almost_empty = (fill_s <= AEMPTY_TH);
endmodule

// File: tb/tb_bramfifo_fwft.sv
// Self-checking bench for bramfifo_fwft (ADDR_ = 4, capacity 18).
// A queue holds every accepted word in order; the head of the queue is the word
// the FIFO must present next, and the queue length is the expected fill.
module tb_bramfifo_fwft;
    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int FWB = AW + 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] model_q [$];

    bramfifo_fwft_if #(.DATA_(DW), .ADDR_(AW)) bus ();

    bramfifo_fwft #(
        .DATA_  (DW),
        .ADDR_  (AW),
        .AFULL_ (14),
        .AEMPTY_(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // One clock: sample handshakes mid-cycle, advance, then update the reference queue
    task automatic tick(output bit pushed, output bit popped, output logic [7:0] got,
                        output logic [7:0] exp, output bit had);
        logic [7:0] wdata;
        bit fl;
        @(negedge clk);
        fl     = bus.flush;
        pushed = bus.in_valid && bus.in_ready && !fl;
        popped = bus.out_valid && bus.out_ready;
        wdata  = bus.in_data;
        got    = bus.out_data;
        had    = (model_q.size() > 0);
        exp    = had ? model_q[0] : 8'h00;
        @(posedge clk);
        #1;
        if (fl) begin
            model_q.delete();
        end else begin
            if (popped && had) void'(model_q.pop_front());
            if (pushed) model_q.push_back(wdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%0h want=0", bus.out_data); end
        total++; if (bus.fill !== 6'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", bus.fill); end
        total++; if (bus.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%0b want=1", bus.almost_empty); end
        total++; if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull got=%0b want=0", bus.almost_full); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", bus.in_ready); end
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0b want=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid got=%0b want=0", bus.out_valid); end
        model_q.delete();
    endtask

    task automatic test_first_word();
        bit pu, po, had;
        logic [7:0] got, exp;
        int first_c = -1, first_pop = -1, last_pop = -1, n = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            bus.in_valid = (c < 5);
            bus.in_data  = 8'(c + 1);
            if (first_c < 0 && bus.out_valid === 1'b1) first_c = c;
            tick(pu, po, got, exp, had);
            if (po) begin
                total++;
                if (!had || got !== exp || got !== 8'(n + 1)) begin
                    bad++; $display("FAIL first_word_data got=%0h want=%0h", got, 8'(n + 1));
                end
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                n++;
            end
        end
        bus.in_valid = 1'b0;
        total++; if (first_c != 3) begin bad++; $display("FAIL first_word_latency got=%0d want=3", first_c); end
        total++; if (n != 5) begin bad++; $display("FAIL first_word_count got=%0d want=5", n); end
        total++; if (last_pop - first_pop != 4) begin bad++; $display("FAIL first_word_gapless got=%0d want=4", last_pop - first_pop); end
        total++; if (bus.fill !== 6'd0) begin bad++; $display("FAIL first_word_fill got=%0d want=0", bus.fill); end
    endtask

    task automatic test_fill();
        bit pu, po, had;
        logic [7:0] got, exp;
        int acc = 0, n = 0, first_pop = -1, last_pop = -1;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(c + 1);
            tick(pu, po, got, exp, had);
            if (pu) acc++;
        end
        bus.in_valid = 1'b0;
        total++; if (acc != 18) begin bad++; $display("FAIL fill_accepted got=%0d want=18", acc); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%0b want=0", bus.in_ready); end
        total++; if (bus.fill !== 6'd18) begin bad++; $display("FAIL fill_level got=%0d want=18", bus.fill); end
        total++; if (bus.almost_full !== 1'b1) begin bad++; $display("FAIL fill_afull got=%0b want=1", bus.almost_full); end
        total++; if (bus.almost_empty !== 1'b0) begin bad++; $display("FAIL fill_aempty got=%0b want=0", bus.almost_empty); end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick(pu, po, got, exp, had);
            if (po) begin
                total++;
                if (!had || got !== exp || got !== 8'(n + 1)) begin
                    bad++; $display("FAIL drain_data got=%0h want=%0h", got, 8'(n + 1));
                end
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                n++;
            end
        end
        total++; if (n != 18) begin bad++; $display("FAIL drain_count got=%0d want=18", n); end
        total++; if (last_pop - first_pop != 17) begin bad++; $display("FAIL drain_gapless got=%0d want=17", last_pop - first_pop); end
        total++; if (bus.fill !== 6'd0) begin bad++; $display("FAIL drain_fill got=%0d want=0", bus.fill); end
    endtask

    task automatic test_stream();
        bit pu, po, had;
        logic [7:0] got, exp;
        int sent = 0, recv = 0, maxfill = 0, fill_err = 0, flag_err = 0, bubbles = 0, stuck = 0;
        for (int c = 0; c < 8000 && recv < 1000; c++) begin
            bus.in_valid  = (sent < 1000);
            bus.in_data   = 8'(sent);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick(pu, po, got, exp, had);
            if (pu) sent++;
            if (po) begin
                total++;
                if (!had || got !== exp) begin bad++; $display("FAIL stream_data got=%0h want=%0h", got, exp); end
                recv++;
            end
            if (int'(bus.fill) > maxfill) maxfill = int'(bus.fill);
            if (int'(bus.fill) != model_q.size()) fill_err++;
            if (bus.almost_full !== (model_q.size() >= 14) || bus.almost_empty !== (model_q.size() <= 2)) flag_err++;
        end
        total++; if (recv != 1000) begin bad++; $display("FAIL stream_count got=%0d want=1000", recv); end
        total++; if (maxfill > 18) begin bad++; $display("FAIL stream_maxfill got=%0d want<=18", maxfill); end
        total++; if (fill_err != 0) begin bad++; $display("FAIL stream_fill_track got=%0d want=0", fill_err); end
        total++; if (flag_err != 0) begin bad++; $display("FAIL stream_flags got=%0d want=0", flag_err); end
        total++; if (sent / 16 < 50) begin bad++; $display("FAIL stream_wraps got=%0d want>=50", sent / 16); end
        // Full-rate phase from empty: push and pop held high, no bubble once primed
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 30 && model_q.size() > 0; c++) tick(pu, po, got, exp, had);
        for (int c = 0; c < 40; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h60 + c);
            if (c >= 4 && bus.out_valid !== 1'b1) bubbles++;
            if (c >= 4 && bus.fill !== 6'd3) stuck++;
            tick(pu, po, got, exp, had);
            if (po) begin
                total++;
                if (!had || got !== exp) begin bad++; $display("FAIL fullrate_data got=%0h want=%0h", got, exp); end
            end
        end
        total++; if (bubbles != 0) begin bad++; $display("FAIL fullrate_bubbles got=%0d want=0", bubbles); end
        total++; if (stuck != 0) begin bad++; $display("FAIL fullrate_fill got=%0d want=0", stuck); end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 30 && model_q.size() > 0; c++) begin
            tick(pu, po, got, exp, had);
            if (po) begin
                total++;
                if (!had || got !== exp) begin bad++; $display("FAIL fullrate_tail got=%0h want=%0h", got, exp); end
            end
        end
    endtask

    task automatic test_simultaneous();
        bit pu, po, had;
        logic [7:0] got, exp;
        int n = 0;
        // fill = 1
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h31;
        tick(pu, po, got, exp, had);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 10 && bus.out_valid !== 1'b1; c++) tick(pu, po, got, exp, had);
        total++; if (bus.fill !== 6'd1) begin bad++; $display("FAIL simul1_pre_fill got=%0d want=1", bus.fill); end
        bus.in_valid = 1'b1; bus.in_data = 8'h32; bus.out_ready = 1'b1;
        tick(pu, po, got, exp, had);
        bus.in_valid = 1'b0;
        total++; if (!(pu && po) || got !== 8'h31) begin bad++; $display("FAIL simul1_pop got=%0h want=31", got); end
        total++; if (bus.fill !== 6'd1) begin bad++; $display("FAIL simul1_fill got=%0d want=1", bus.fill); end
        for (int c = 0; c < 8; c++) begin
            tick(pu, po, got, exp, had);
            if (po) begin
                total++;
                if (got !== 8'h32) begin bad++; $display("FAIL simul1_next got=%0h want=32", got); end
                n++;
            end
        end
        total++; if (n != 1) begin bad++; $display("FAIL simul1_count got=%0d want=1", n); end
        // fill = 18
        bus.out_ready = 1'b0;
        for (int c = 0; c < 30 && model_q.size() < 18; c++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(8'h40 + c);
            tick(pu, po, got, exp, had);
        end
        total++; if (bus.fill !== 6'd18) begin bad++; $display("FAIL simul18_pre_fill got=%0d want=18", bus.fill); end
        bus.in_valid = 1'b1; bus.in_data = 8'h70; bus.out_ready = 1'b1;
        tick(pu, po, got, exp, had);
        total++; if (pu || !po) begin bad++; $display("FAIL simul18_refuse got=%0b%0b want=01", pu, po); end
        total++; if (bus.fill !== 6'd17) begin bad++; $display("FAIL simul18_fill got=%0d want=17", bus.fill); end
        bus.in_data = 8'h71;
        tick(pu, po, got, exp, had);
        total++; if (!(pu && po)) begin bad++; $display("FAIL simul17_both got=%0b%0b want=11", pu, po); end
        total++; if (bus.fill !== 6'd17) begin bad++; $display("FAIL simul17_fill got=%0d want=17", bus.fill); end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 40 && model_q.size() > 0; c++) begin
            tick(pu, po, got, exp, had);
            if (po) begin
                total++;
                if (!had || got !== exp) begin bad++; $display("FAIL simul18_order got=%0h want=%0h", got, exp); end
            end
        end
    endtask

    task automatic test_flush();
        bit pu, po, had;
        logic [7:0] got, exp;
        int n = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(8'h20 + c);
            tick(pu, po, got, exp, had);
        end
        bus.in_data = 8'h27; bus.out_ready = 1'b1;
        tick(pu, po, got, exp, had);
        total++; if (bus.fill !== 6'd7) begin bad++; $display("FAIL flush_pre_fill got=%0d want=7", bus.fill); end
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.out_ready = 1'b0;
        tick(pu, po, got, exp, had);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        total++; if (bus.fill !== 6'd0) begin bad++; $display("FAIL flush_fill got=%0d want=0", bus.fill); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.almost_empty !== 1'b1) begin bad++; $display("FAIL flush_aempty got=%0b want=1", bus.almost_empty); end
        bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.out_ready = 1'b1;
        tick(pu, po, got, exp, had);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(pu, po, got, exp, had);
            if (po) begin
                total++;
                if (n == 0 && got !== 8'hAA) begin bad++; $display("FAIL flush_first got=%0h want=aa", got); end
                if (n > 0) begin bad++; $display("FAIL flush_stale got=%0h want=none", got); end
                n++;
            end
        end
        total++; if (n != 1) begin bad++; $display("FAIL flush_count got=%0d want=1", n); end
    endtask

    task automatic test_reset_mid();
        bit pu, po, had;
        logic [7:0] got, exp;
        int n = 0;
        int run = $urandom_range(5, 30);
        for (int c = 0; c < run; c++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(8'h10 + c);
            bus.out_ready = ($urandom_range(0, 1) != 0);
            tick(pu, po, got, exp, had);
        end
        #($urandom_range(1, 7));
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL midrst_out_data got=%0h want=0", bus.out_data); end
        total++; if (bus.fill !== 6'd0) begin bad++; $display("FAIL midrst_fill got=%0d want=0", bus.fill); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%0b want=0", bus.in_ready); end
        total++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin
            bad++; $display("FAIL midrst_flags got=%0b%0b want=10", bus.almost_empty, bus.almost_full);
        end
        model_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_release got=%0b%0b want=10", bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            bus.in_valid = (c < 5); bus.in_data = 8'(8'hC0 + c);
            tick(pu, po, got, exp, had);
            if (po) begin
                total++;
                if (!had || got !== exp || got !== 8'(8'hC0 + n)) begin
                    bad++; $display("FAIL midrst_data got=%0h want=%0h", got, 8'(8'hC0 + n));
                end
                n++;
            end
        end
        bus.in_valid = 1'b0;
        total++; if (n != 5) begin bad++; $display("FAIL midrst_count got=%0d want=5", n); end
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        test_reset();
        test_first_word();
        test_fill();
        test_stream();
        test_simultaneous();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
